// File: rtl/bool_func_sweep_ctrl.sv
// Exhaustive sweeper for a 6-input Boolean block: walks all 64 vectors, samples Y, checks it against a golden mask.
// Each vector is held SETTLE_CYC cycles; done pulses 1+64*SETTLE_CYC cycles after start; abort cancels with no done.
module bool_func_sweep_ctrl #(
  parameter logic [63:0] MINTERM_MASK = 64'h0500_5500_1511_1511,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        Y_in,
  output logic [5:0]  drv_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_count,
  output logic [5:0]  first_err_idx,
  output logic        first_err_vld,
  output logic [63:0] obs_table
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t      state_q;
  logic [5:0]  idx_q;
  logic [5:0]  drv_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [6:0]  err_q;
  logic [6:0]  err_d;
  logic [5:0]  ferr_idx_q;
  logic        ferr_vld_q;
  logic [63:0] obs_q;
  logic        mismatch;

  assign mismatch = (Y_in != MINTERM_MASK[idx_q]);
  // pass is decided from err_d so the last vector's verdict is included
  assign err_d    = err_q + {6'd0, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 6'd0;
      drv_q      <= 6'd0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 7'd0;
      ferr_idx_q <= 6'd0;
      ferr_vld_q <= 1'b0;
      obs_q      <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= SETTLE;
            busy_q     <= 1'b1;
            idx_q      <= 6'd0;
            drv_q      <= 6'd0;
            cnt_q      <= 4'd0;
            err_q      <= 7'd0;
            ferr_idx_q <= 6'd0;
            ferr_vld_q <= 1'b0;
            obs_q      <= 64'd0;
            pass_q     <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            drv_q   <= 6'd0;
            idx_q   <= 6'd0;
            cnt_q   <= 4'd0;
            pass_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            obs_q[idx_q] <= Y_in;
            err_q        <= err_d;
            cnt_q        <= 4'd0;
            if (mismatch && !ferr_vld_q) begin
              ferr_idx_q <= idx_q;
              ferr_vld_q <= 1'b1;
            end
            if (idx_q == 6'd63) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 7'd0);
            end else begin
              idx_q <= idx_q + 6'd1;
              drv_q <= idx_q + 6'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drv_in        = drv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_idx_q;
  assign first_err_vld = ferr_vld_q;
  assign obs_table     = obs_q;

endmodule

// File: tb/tb_bool_func_sweep_ctrl.sv
// Scoreboard bench for bool_func_sweep_ctrl: the stimulus thread queues expected sweep results,
// and a monitor thread checks them on every done pulse and tracks the drv_in walk while busy.
module tb_bool_func_sweep_ctrl;

  localparam int          SC   = 2;
  localparam logic [63:0] MASK = 64'h0500_5500_1511_1511;

  typedef struct {
    logic [63:0] obs;
    int          err;
    int          fidx;
    bit          fvld;
    bit          pass;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        Y_in;
  logic [5:0]  drv_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_count;
  logic [5:0]  first_err_idx;
  logic        first_err_vld;
  logic [63:0] obs_table;

  logic [63:0] act_tbl = MASK;
  int          cyc = 0;
  int          sweep_start = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        last_e;

  bool_func_sweep_ctrl #(.MINTERM_MASK(MASK), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Y_in(Y_in),
    .drv_in(drv_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_vld(first_err_vld), .obs_table(obs_table)
  );

  // function under test: whatever truth table the current scenario installs
  assign Y_in = act_tbl[drv_in];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [63:0] tbl);
    exp_t        e;
    logic [63:0] diff;
    diff   = tbl ^ MASK;
    e.obs  = tbl;
    e.err  = $countones(diff);
    e.fvld = (diff != 64'd0);
    e.fidx = 0;
    for (int i = 63; i >= 0; i--) if (diff[i]) e.fidx = i;
    e.pass = (e.err == 0);
    e.done_cyc = 0;
    return e;
  endfunction

  // Monitor: drv_in must equal elapsed_cycles/SC while busy; every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && busy) chk("drv_walk", 64'(drv_in), 64'((cyc - sweep_start) / SC));
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        chk("pass", 64'(pass), 64'(mon_e.pass));
        chk("err_count", 64'(err_count), 64'(mon_e.err));
        chk("first_err_vld", 64'(first_err_vld), 64'(mon_e.fvld));
        chk("first_err_idx", 64'(first_err_idx), 64'(mon_e.fidx));
        chk("obs_table", obs_table, mon_e.obs);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic begin_sweep(input logic [63:0] tbl, input bit with_abort);
    act_tbl = tbl;
    @(posedge clk); #1;
    start       = 1'b1;
    abort       = with_abort;
    sweep_start = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_drv(input logic [5:0] target, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (drv_in == target && busy) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: drv_in never reached %0d, last value %0d", nm, target, drv_in);
    end
  endtask

  task automatic run_sweep(input logic [63:0] tbl, input bit with_abort, input bit extra_start);
    exp_t e;
    e = model(tbl);
    begin_sweep(tbl, with_abort);
    e.done_cyc = sweep_start + 64 * SC;
    exp_q.push_back(e);
    last_e = e;
    if (extra_start) begin
      repeat (8) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: %0d sweep results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("drv_hold_63", 64'(drv_in), 64'd63);
    chk("err_count_held", 64'(err_count), 64'(last_e.err));
    chk("obs_table_held", obs_table, last_e.obs);
  endtask

  initial begin
    logic [63:0] tbl;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_drv_in", 64'(drv_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_obs_table", obs_table, 64'd0);

    run_sweep(MASK, 1'b0, 1'b0);
    run_sweep(64'd0, 1'b0, 1'b0);
    run_sweep(~MASK, 1'b0, 1'b0);
    tbl = MASK;
    tbl[46] = 1'b0;
    run_sweep(tbl, 1'b0, 1'b0);

    // abort lands on the sample edge of vector 20, so that sample must be discarded
    begin_sweep(MASK, 1'b0);
    wait_drv(6'd20, "abort_wait");
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_drv_in", 64'(drv_in), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_pass", 64'(pass), 64'd0);
    chk("abort_err_count", 64'(err_count), 64'd0);
    chk("abort_partial_obs", obs_table, MASK & 64'h0000_0000_000F_FFFF);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    run_sweep(MASK, 1'b1, 1'b0);

    begin_sweep(~MASK, 1'b0);
    wait_drv(6'd33, "reset_wait");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_drv_in", 64'(drv_in), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_pass", 64'(pass), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    chk("midrst_first_err_idx", 64'(first_err_idx), 64'd0);
    chk("midrst_first_err_vld", 64'(first_err_vld), 64'd0);
    chk("midrst_obs_table", obs_table, 64'd0);

    tbl = MASK;
    tbl[$urandom_range(63, 0)] ^= 1'b1;
    run_sweep(tbl, 1'b0, 1'b1);

    for (int r = 0; r < 5; r++) begin
      tbl = MASK;
      for (int k = 0; k < int'($urandom_range(6, 0)); k++) tbl[$urandom_range(63, 0)] ^= 1'b1;
      if (r == 4) tbl = {$urandom, $urandom};
      run_sweep(tbl, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bool_func_sweep_ctrl.md
Name: bool_func_sweep_ctrl

Overview:
- Exhaustive truth-table sequencer for a 6-input combinational Boolean function block (inputs A..F, A = MSB; output Y).
- On start, it drives all 64 input combinations in ascending order, waits a settle time, and samples Y.
- Each sample is compared against a golden minterm mask; the block accumulates mismatch statistics and the observed truth table.
- Used on-board and in simulation to sign off optimized vs. unoptimized implementations of the same function.

Parameters:
- MINTERM_MASK, 64'h0500_5500_1511_1511: golden truth table. Bit i = expected Y for input index i = {A,B,C,D,E,F}. Default encodes minterms 0,4,8,10,12,16,20,24,26,28,40,42,44,46,56,58.
- SETTLE_CYC, 2: clock cycles each vector is held before Y is sampled. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; begins a sweep. Ignored unless in IDLE.
- abort  in  1  terminates an active sweep and returns to IDLE; no done pulse.
- Y_in  in  1  output Y of the function under test.
- drv_in  out  6  registered vector to function inputs: [5]=A, [4]=B, [3]=C, [2]=D, [1]=E, [0]=F.
- busy  out  1  high while a sweep is active (SETTLE state).
- done  out  1  one-cycle pulse when a sweep completes normally.
- pass  out  1  valid after done: 1 if zero mismatches.
- err_count  out  7  number of mismatching vectors, 0..64.
- first_err_idx  out  6  index of the first mismatching vector.
- first_err_vld  out  1  first_err_idx holds a valid index.
- obs_table  out  64  observed Y per index; bit i = sampled Y for vector i.

Behaviour:
- Single clock domain, synchronous active-high reset. Reset values: drv_in=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_vld=0, obs_table=0, state=IDLE, idx=0, settle counter=0.
- States:
  - IDLE: if start=1, clear err_count, first_err_vld, first_err_idx, obs_table and pass; set idx=0, drv_in=0, cnt=0; go to SETTLE.
  - SETTLE: busy=1. cnt increments each cycle. When cnt==SETTLE_CYC-1, sample Y_in on that edge:
    - obs_table[idx] <= Y_in.
    - On mismatch vs MINTERM_MASK[idx]: err_count++; if first_err_vld==0, set first_err_idx=idx and first_err_vld=1.
    - If idx==63, go to DONE. Otherwise idx++, drv_in=idx+1, cnt=0.
  - DONE: one cycle only; done=1, busy=0, pass=(final err_count==0); go to IDLE. pass must include the last vector's result.
- Latency: start sampled at edge 0; drv_in=0 visible from cycle 1. Each vector is held exactly SETTLE_CYC cycles. busy is high for 64*SETTLE_CYC cycles; done is high in cycle 1+64*SETTLE_CYC.
- drv_in changes only on sample edges, so the DUT sees glitch-free inputs. drv_in holds 63 after a sweep until the next start, abort or reset.
- err_count is 7 bits and saturates naturally at 64; no overflow.
- abort has priority over sampling in the same cycle: that sample is discarded. Go to IDLE with drv_in=0 and busy=0; done stays 0. Partial results remain readable; pass=0.
- start while in SETTLE or DONE: ignored.
- start and abort together in IDLE: start wins, sweep begins.
- rst has priority over everything; mid-sweep it restores all reset values in the next cycle.
- Results (pass, err_count, first_err_*, obs_table) are held until the next accepted start or reset.

Test Plan:
- SETTLE_CYC=2, Y_in from a correct model of MINTERM_MASK; pulse start -> drv_in walks 0..63, two cycles each. done in cycle 129 only; pass=1, err_count=0, first_err_vld=0, obs_table=64'h0500_5500_1511_1511.
- Y_in tied 0 -> err_count=16, first_err_idx=0, first_err_vld=1, pass=0, obs_table=0.
- Y_in = inverted model -> err_count=64, first_err_idx=0, obs_table=64'hFAFF_AAFF_EAEE_EAEE.
- Model correct except index 46 forced to 0 -> err_count=1, first_err_idx=46, pass=0, obs_table bit 46=0.
- abort asserted while drv_in=20 -> next cycle state IDLE, busy=0, drv_in=0, no done. A subsequent start gives a full clean sweep with pass=1.
- rst asserted at drv_in=33 -> all outputs at reset values next cycle. start pulsed at cycle 10 of an active sweep -> ignored; sweep finishes at its original done cycle.
